// File: rtl/bn_stream_if.sv
// Stream, parameter-write and status signals of bn_stream.
// master = the block's environment, slave = bn_stream itself.
interface bn_stream_if #(
   parameter int CHANNELS  = 32,
   parameter int BIT_WIDTH = 16
) ();
   localparam int CW = $clog2(CHANNELS);

   logic                        in_valid;
   logic                        in_ready;
   logic                        in_first;
   logic signed [BIT_WIDTH-1:0] in_data;
   logic                        out_valid;
   logic                        out_ready;
   logic signed [BIT_WIDTH-1:0] out_data;
   logic [CW-1:0]               out_chan;
   logic                        prm_we;
   logic [1:0]                  prm_sel;
   logic [CW-1:0]               prm_addr;
   logic signed [BIT_WIDTH-1:0] prm_data;
   logic                        busy;
   logic                        prm_err;

   modport master (
      output in_valid, in_first, in_data, out_ready,
             prm_we, prm_sel, prm_addr, prm_data,
      input  in_ready, out_valid, out_data, out_chan, busy, prm_err
   );

   modport slave (
      input  in_valid, in_first, in_data, out_ready,
             prm_we, prm_sel, prm_addr, prm_data,
      output in_ready, out_valid, out_data, out_chan, busy, prm_err
   );
endinterface

// File: rtl/bn_stream.sv
// Streaming per-channel batch-norm: center, gamma scale, inv_std scale, beta add + saturate.
// Optional fused ReLU on the saturated result when macro BN_RELU_EN is defined.
module bn_stream #(
   parameter int CHANNELS  = 32,
   parameter int BIT_WIDTH = 16,
   parameter int FRAC_BITS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   bn_stream_if.slave bus
);
   localparam int CW = $clog2(CHANNELS);
   localparam int W0 = BIT_WIDTH + 1;
   localparam int W1 = 2 * BIT_WIDTH + 1;
   localparam int W2 = 3 * BIT_WIDTH + 1;
   localparam int W3 = 3 * BIT_WIDTH + 2;
   localparam logic signed [BIT_WIDTH-1:0] ONE  = BIT_WIDTH'(1 << FRAC_BITS);
   localparam logic signed [W3-1:0]        SMAX = {{(W3-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
   localparam logic signed [W3-1:0]        SMIN = {{(W3-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

   function automatic logic signed [BIT_WIDTH-1:0] sat(input logic signed [W3-1:0] v);
      logic signed [BIT_WIDTH-1:0] r;
      if (v > SMAX)
         r = {1'b0, {(BIT_WIDTH-1){1'b1}}};
      else if (v < SMIN)
         r = {1'b1, {(BIT_WIDTH-1){1'b0}}};
      else
         r = v[BIT_WIDTH-1:0];
`ifdef BN_RELU_EN
      if (r[BIT_WIDTH-1])
         r = '0;
`endif
      return r;
   endfunction

   logic signed [BIT_WIDTH-1:0] gamma_t [CHANNELS];
   logic signed [BIT_WIDTH-1:0] beta_t  [CHANNELS];
   logic signed [BIT_WIDTH-1:0] mean_t  [CHANNELS];
   logic signed [BIT_WIDTH-1:0] inv_t   [CHANNELS];

   logic                        vld_p0, vld_p1, vld_p2, vld_p3;
   logic [CW-1:0]               cnt, chan_in, chan_p0, chan_p1, chan_p2, chan_p3;
   logic signed [W0-1:0]        cen, cen_p0;
   logic signed [W1-1:0]        prod1, gam_p1;
   logic signed [W2-1:0]        prod2, inv_p2;
   logic signed [W3-1:0]        sum3;
   logic signed [BIT_WIDTH-1:0] data_p3;
   logic                        stall, accept, busy_w, addr_ok, wr_ok;

   // One global stall: a blocked output freezes every stage, so nothing is lost or reordered.
   assign stall   = vld_p3 && !bus.out_ready;
   assign accept  = bus.in_valid && !stall;
   assign busy_w  = vld_p0 || vld_p1 || vld_p2 || vld_p3;
   assign addr_ok = 32'(bus.prm_addr) < 32'(CHANNELS);
   assign wr_ok   = !busy_w && !bus.in_valid && addr_ok;

   assign bus.in_ready  = !stall;
   assign bus.out_valid = vld_p3;
   assign bus.out_data  = data_p3;
   assign bus.out_chan  = chan_p3;
   assign bus.busy      = busy_w;

   always_comb begin
      chan_in = bus.in_first ? '0 : cnt;
      cen     = W0'(bus.in_data) - W0'(mean_t[chan_in]);
      prod1   = W1'(cen_p0) * W1'(gamma_t[chan_p0]);
      prod2   = W2'(gam_p1) * W2'(inv_t[chan_p1]);
      sum3    = W3'(inv_p2) + W3'(beta_t[chan_p2]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (accept)
         cnt <= (chan_in == CW'(CHANNELS - 1)) ? '0 : chan_in + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         vld_p3 <= 1'b0;
      end else if (!stall) begin
         vld_p0 <= bus.in_valid;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
         vld_p3 <= vld_p2;
      end
   end

   always_ff @(posedge clk) begin
      if (!stall) begin
         // p0: center on mean
         cen_p0  <= cen;
         chan_p0 <= chan_in;
         // p1: gamma scale, floor shift, full width kept
         gam_p1  <= prod1 >>> FRAC_BITS;
         chan_p1 <= chan_p0;
         // p2: inv_std scale
         inv_p2  <= prod2 >>> FRAC_BITS;
         chan_p2 <= chan_p1;
      end
   end

   // p3: beta add and saturate; output registers carry a reset value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_p3 <= '0;
         chan_p3 <= '0;
      end else if (!stall) begin
         data_p3 <= sat(sum3);
         chan_p3 <= chan_p2;
      end
   end

   // Tables only change while the pipe is empty and no beat is offered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            gamma_t[i] <= ONE;
            beta_t[i]  <= '0;
            mean_t[i]  <= '0;
            inv_t[i]   <= ONE;
         end
         bus.prm_err <= 1'b0;
      end else begin
         bus.prm_err <= bus.prm_we && !wr_ok;
         if (bus.prm_we && wr_ok) begin
            case (bus.prm_sel)
               2'd0: gamma_t[bus.prm_addr] <= bus.prm_data;
               2'd1: beta_t[bus.prm_addr]  <= bus.prm_data;
               2'd2: mean_t[bus.prm_addr]  <= bus.prm_data;
               2'd3: inv_t[bus.prm_addr]   <= bus.prm_data;
            endcase
         end
      end
   end
endmodule
